ahb_master: RTL and testbench
=============================

Name: ahb_master

Overview:
AHB-Lite initiator that turns the team's simple local request interface (valid/ready, rd0_wr1, addr, wr_data) into pipelined AHB single transfers.
- Returns one response per transfer: read data and error flag.
- Sits between an internal requester (DMA/CPU-side bridge) and the AHB interconnect.
- Drives the slaves that implement the local request/response interface on their far side.

Parameters:
DATA_WIDTH, 32, width of local data, o_hwdata and i_hrdata
ADDR_WIDTH, 32, width of local address and o_haddr
HSIZE_VAL, 3'b010, constant value driven on o_hsize (word transfers)

Ports:
i_clk_ahb  in  1  AHB clock
i_rstn_ahb  in  1  asynchronous active-low reset
i_valid  in  1  local request valid
i_rd0_wr1  in  1  request type: 0 read, 1 write
i_addr  in  ADDR_WIDTH  request address
i_wr_data  in  DATA_WIDTH  write data, sampled together with the request
o_ready  out  1  request accepted when i_valid && o_ready
o_rsp_valid  out  1  one-cycle pulse per completed transfer
o_rsp_rd0_wr1  out  1  type of the completed transfer
o_rsp_err  out  1  completed transfer got ERROR response
o_rd_data  out  DATA_WIDTH  read data, valid with o_rsp_valid && !o_rsp_rd0_wr1, else 0
o_htrans  out  1  1 = NONSEQ, 0 = IDLE (codebase 1-bit htrans encoding)
o_hwrite  out  1  AHB write
o_haddr  out  ADDR_WIDTH  AHB address
o_hsize  out  3  constant HSIZE_VAL
o_hburst  out  3  constant 3'b000 (SINGLE)
o_hprot  out  4  constant 4'b0011
o_hmastlock  out  1  constant 0
o_hwdata  out  DATA_WIDTH  write data during the data phase
i_hready  in  1  bus ready (transfer completes / address sampled)
i_hresp  in  1  0 OKAY, 1 ERROR
i_hrdata  in  DATA_WIDTH  read data

Behaviour:
Reset values:
- All outputs 0; o_hsize = HSIZE_VAL; o_ready = 1.
- Both pipeline stages empty.

Two registered stages:
- Address stage (ap_*): valid, write, addr, wdata. o_htrans = ap_valid, o_hwrite = ap_write, o_haddr = ap_addr.
- Data stage (dp_*): valid, write, wdata. o_hwdata = dp_wdata, held while dp_valid and !i_hready.

FSM state is {ap_valid, dp_valid}:
- IDLE = 00, ADDR = 10, DATA = 01, ADDR_DATA = 11.
- Transitions occur only on clock edges and depend on i_hready and accept.

Address stage advance:
- adv = ap_valid && i_hready.
- On adv, ap_* moves into dp_*. Otherwise dp_valid clears when i_hready && dp_valid.

Accept:
- o_ready = !ap_valid || i_hready (combinational).
- On accept, i_* loads ap_*. If ap_* is advancing and there is no accept, ap_valid clears.

Throughput:
- Back-to-back requests with i_hready=1 give one transfer per cycle.
- Address of N+1 overlaps the data phase of N.

Completion:
- When dp_valid && i_hready, register next cycle: o_rsp_valid=1, o_rsp_rd0_wr1=dp_write, o_rsp_err=i_hresp.
- Also register o_rd_data = dp_write ? 0 : i_hrdata.
- Response latency: 1 cycle after the data phase completes.

Wait states (i_hready=0):
- ap_*, dp_*, o_haddr, o_hwrite, o_htrans and o_hwdata all hold.
- o_ready is 0 if ap_valid.

ERROR response (two-cycle, i_hresp=1 with i_hready 0 then 1):
- The first cycle is a wait state.
- Completion on the second cycle reports o_rsp_err=1.
- A pending address-phase transfer is not cancelled and proceeds normally.

Simultaneous events:
- Accept and advance in the same cycle is legal.
- Completion of N and advance of N+1 in the same cycle is legal.

Reset mid-operation:
- Stages are flushed immediately and no response is generated for in-flight transfers.
- o_htrans=0 asynchronously.

The local requester must hold i_* stable while i_valid && !o_ready.

Decomposition:
Shared package ahb_pkg:
- htrans encoding (IDLE/NONSEQ).
- HBURST_SINGLE, HRESP_OKAY/ERROR.
- HSIZE_WORD.
- FSM state enum state_t {IDLE, ADDR, DATA, ADDR_DATA}.

Single flat module; no sub-module is warranted.

Test Plan:
- Single write addr=0x10 data=0xA5A5_0001, i_hready=1 -> cycle1: o_htrans=1, o_haddr=0x10, o_hwrite=1; cycle2: o_hwdata=0xA5A5_0001; cycle3: o_rsp_valid=1, o_rsp_err=0.
- Single read addr=0x20, i_hrdata=0xDEAD_BEEF in the data phase -> o_rsp_valid=1, o_rd_data=0xDEAD_BEEF, o_rsp_rd0_wr1=0.
- Four back-to-back writes 0x0/0x4/0x8/0xC with i_hready=1 -> o_ready stays 1, o_haddr increments each cycle, hwdata lags address by 1, four consecutive o_rsp_valid pulses.
- Write then read with i_hready=0 for 3 cycles during the write data phase -> o_haddr=read addr, o_hwdata held for 3 cycles, o_ready=0, responses still ordered write then read.
- ERROR on read addr=0x40: i_hresp=1/i_hready=0, then i_hresp=1/i_hready=1 -> o_rsp_err=1 for that read; the following queued write completes with o_rsp_err=0.
- Reset asserted during ADDR_DATA -> all outputs 0 immediately; after release o_ready=1 and no stray o_rsp_valid.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator pipeline state type.
package ahb_pkg;

  // 1-bit htrans encoding used across this codebase (only IDLE and NONSEQ issued)
  localparam logic       HTRANS_IDLE   = 1'b0;
  localparam logic       HTRANS_NONSEQ = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // State bits are {address stage occupied, data stage occupied}
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DATA      = 2'b01,
    ADDR      = 2'b10,
    ADDR_DATA = 2'b11
  } state_t;

endpackage

// File: rtl/ahb_master.sv
// AHB-Lite initiator: converts valid/ready local requests into pipelined
// single transfers and returns one registered response per transfer.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [2:0]      HSIZE_VAL  = HSIZE_WORD
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_rd0_wr1,
  output logic                  o_rsp_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_htrans,
  output logic                  o_hwrite,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  state_t                state;
  logic                  ap_valid;
  logic                  dp_valid;
  logic                  ap_write;
  logic [ADDR_WIDTH-1:0] ap_addr;
  logic [DATA_WIDTH-1:0] ap_wdata;
  logic                  dp_write;
  logic [DATA_WIDTH-1:0] dp_wdata;

  logic                  accept;
  logic                  adv;
  logic                  done;
  logic                  ap_next;
  logic                  dp_next;

  assign ap_valid = state[1];
  assign dp_valid = state[0];

  // The address stage can take a new request whenever it is empty or draining
  assign o_ready = !ap_valid || i_hready;
  assign accept  = i_valid && o_ready;
  assign adv     = ap_valid && i_hready;
  assign done    = dp_valid && i_hready;

  // Next occupancy of each stage; a completing data phase is refilled by an advancing address
  always_comb begin
    ap_next = ap_valid;
    dp_next = dp_valid;
    if (accept) begin
      ap_next = 1'b1;
    end else if (adv) begin
      ap_next = 1'b0;
    end
    if (adv) begin
      dp_next = 1'b1;
    end else if (done) begin
      dp_next = 1'b0;
    end
  end

  // Pipeline occupancy FSM; reset flushes both stages so in-flight transfers are dropped
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state <= IDLE;
    end else begin
      state <= state_t'({ap_next, dp_next});
    end
  end

  // Address-stage payload: captured on accept, held through wait states
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      ap_write <= 1'b0;
      ap_addr  <= '0;
      ap_wdata <= '0;
    end else if (accept) begin
      ap_write <= i_rd0_wr1;
      ap_addr  <= i_addr;
      ap_wdata <= i_wr_data;
    end
  end

  // Data-stage payload: follows the address stage when it advances, else holds hwdata
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (adv) begin
      dp_write <= ap_write;
      dp_wdata <= ap_wdata;
    end
  end

  // Response is registered one cycle after the data phase completes; idle cycles read as zero
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      o_rsp_valid   <= 1'b0;
      o_rsp_rd0_wr1 <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rd_data     <= '0;
    end else if (done) begin
      o_rsp_valid   <= 1'b1;
      o_rsp_rd0_wr1 <= dp_write;
      o_rsp_err     <= (i_hresp == HRESP_ERROR);
      o_rd_data     <= dp_write ? '0 : i_hrdata;
    end else begin
      o_rsp_valid   <= 1'b0;
      o_rsp_rd0_wr1 <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rd_data     <= '0;
    end
  end

  assign o_htrans    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign o_hwrite    = ap_write;
  assign o_haddr     = ap_addr;
  assign o_hwdata    = dp_wdata;
  assign o_hsize     = HSIZE_VAL;
  assign o_hburst    = HBURST_SINGLE;
  assign o_hprot     = HPROT_DATA;
  assign o_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_master.sv
// Directed testbench for ahb_master: single transfers, back-to-back, wait
// states, ERROR response and reset during an active pipeline.
module tb_ahb_master;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic        rd0_wr1;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        rsp_valid;
  logic        rsp_rd0_wr1;
  logic        rsp_err;
  logic [31:0] rd_data;
  logic        htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int checks;
  int failures;

  ahb_master dut (
    .i_clk_ahb     (clk),
    .i_rstn_ahb    (rstn),
    .i_valid       (valid),
    .i_rd0_wr1     (rd0_wr1),
    .i_addr        (addr),
    .i_wr_data     (wr_data),
    .o_ready       (ready),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rd0_wr1 (rsp_rd0_wr1),
    .o_rsp_err     (rsp_err),
    .o_rd_data     (rd_data),
    .o_htrans      (htrans),
    .o_hwrite      (hwrite),
    .o_haddr       (haddr),
    .o_hsize       (hsize),
    .o_hburst      (hburst),
    .o_hprot       (hprot),
    .o_hmastlock   (hmastlock),
    .o_hwdata      (hwdata),
    .i_hready      (hready),
    .i_hresp       (hresp),
    .i_hrdata      (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid   = 1'b0;
    rd0_wr1 = 1'b0;
    addr    = '0;
    wr_data = '0;
    hready  = 1'b1;
    hresp   = 1'b0;
    hrdata  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (htrans !== 1'b0) begin failures++; $display("FAIL rst_htrans got=%b exp=0", htrans); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (hsize !== 3'b010) begin failures++; $display("FAIL rst_hsize got=%b exp=010", hsize); end
    checks++; if (hburst !== 3'b000 || hprot !== 4'b0011 || hmastlock !== 1'b0)
      begin failures++; $display("FAIL rst_consts got=%b/%b/%b exp=000/0011/0", hburst, hprot, hmastlock); end
    checks++; if (haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0 || rd_data !== 32'h0)
      begin failures++; $display("FAIL rst_zero got=%h/%h/%b/%h exp=0", haddr, hwdata, hwrite, rd_data); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h10; wr_data = 32'hA5A5_0001;
    tick();                                   // accepted
    valid = 1'b0; #1;
    checks++; if (htrans !== 1'b1 || hwrite !== 1'b1 || haddr !== 32'h10)
      begin failures++; $display("FAIL wr_addr_phase got=%b/%b/%h exp=1/1/00000010", htrans, hwrite, haddr); end
    tick();
    checks++; if (hwdata !== 32'hA5A5_0001 || htrans !== 1'b0)
      begin failures++; $display("FAIL wr_data_phase got=%h/%b exp=a5a50001/0", hwdata, htrans); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_early_rsp got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rd0_wr1 !== 1'b1 || rd_data !== 32'h0)
      begin failures++; $display("FAIL wr_rsp got=%b/%b/%b/%h exp=1/0/1/0", rsp_valid, rsp_err, rsp_rd0_wr1, rd_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_single_read();
    valid = 1'b1; rd0_wr1 = 1'b0; addr = 32'h20; wr_data = 32'h0;
    tick();
    valid = 1'b0; #1;
    checks++; if (htrans !== 1'b1 || hwrite !== 1'b0 || haddr !== 32'h20)
      begin failures++; $display("FAIL rd_addr_phase got=%b/%b/%h exp=1/0/00000020", htrans, hwrite, haddr); end
    tick();
    hrdata = 32'hDEAD_BEEF;
    tick();
    hrdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd0_wr1 !== 1'b0 || rd_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0)
      begin failures++; $display("FAIL rd_rsp got=%b/%b/%h/%b exp=1/0/deadbeef/0", rsp_valid, rsp_rd0_wr1, rd_data, rsp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [4];
    int          rsp_cnt;
    dat[0] = 32'h1000_0000; dat[1] = 32'h1000_0001; dat[2] = 32'h1000_0002; dat[3] = 32'h1000_0003;
    rsp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'(4 * k); wr_data = dat[k];
      #1;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", k, ready); end
      tick();
      checks++; if (htrans !== 1'b1 || haddr !== 32'(4 * k))
        begin failures++; $display("FAIL b2b_haddr%0d got=%b/%h exp=1/%h", k, htrans, haddr, 32'(4 * k)); end
      if (k > 0) begin
        checks++; if (hwdata !== dat[k-1])
          begin failures++; $display("FAIL b2b_hwdata%0d got=%h exp=%h", k, hwdata, dat[k-1]); end
      end
      if (k > 1) begin
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp%0d got=%b exp=1", k - 2, rsp_valid); end
      end
    end
    valid = 1'b0;
    tick();
    checks++; if (hwdata !== dat[3] || htrans !== 1'b0)
      begin failures++; $display("FAIL b2b_last_hwdata got=%h/%b exp=%h/0", hwdata, htrans, dat[3]); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp2 got=%b exp=1", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rd0_wr1 !== 1'b1)
      begin failures++; $display("FAIL b2b_rsp3 got=%b/%b exp=1/1", rsp_valid, rsp_rd0_wr1); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_rsp_end got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_wait_states();
    valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h50; wr_data = 32'h1111_0050;
    tick();                                   // write accepted
    rd0_wr1 = 1'b0; addr = 32'h54; wr_data = 32'h0;
    tick();                                   // write advances, read accepted
    valid = 1'b0; hready = 1'b0; #1;
    for (int w = 0; w < 3; w++) begin
      checks++; if (haddr !== 32'h54 || htrans !== 1'b1 || hwrite !== 1'b0)
        begin failures++; $display("FAIL ws_haddr%0d got=%h/%b/%b exp=00000054/1/0", w, haddr, htrans, hwrite); end
      checks++; if (hwdata !== 32'h1111_0050)
        begin failures++; $display("FAIL ws_hwdata%0d got=%h exp=11110050", w, hwdata); end
      checks++; if (ready !== 1'b0 || rsp_valid !== 1'b0)
        begin failures++; $display("FAIL ws_ready%0d got=%b/%b exp=0/0", w, ready, rsp_valid); end
      tick();
    end
    hready = 1'b1;
    tick();                                   // write completes, read advances
    hrdata = 32'hCAFE_0054;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd0_wr1 !== 1'b1 || rsp_err !== 1'b0)
      begin failures++; $display("FAIL ws_rsp_wr got=%b/%b/%b exp=1/1/0", rsp_valid, rsp_rd0_wr1, rsp_err); end
    tick();
    hrdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd0_wr1 !== 1'b0 || rd_data !== 32'hCAFE_0054)
      begin failures++; $display("FAIL ws_rsp_rd got=%b/%b/%h exp=1/0/cafe0054", rsp_valid, rsp_rd0_wr1, rd_data); end
    tick();
  endtask

  task automatic test_error();
    valid = 1'b1; rd0_wr1 = 1'b0; addr = 32'h40; wr_data = 32'h0;
    tick();                                   // read accepted
    rd0_wr1 = 1'b1; addr = 32'h44; wr_data = 32'h2222_0044;
    tick();                                   // read in data phase, write in address phase
    valid = 1'b0; hresp = 1'b1; hready = 1'b0;
    tick();                                   // first ERROR cycle is a wait state
    checks++; if (rsp_valid !== 1'b0 || haddr !== 32'h44 || htrans !== 1'b1)
      begin failures++; $display("FAIL err_wait got=%b/%h/%b exp=0/00000044/1", rsp_valid, haddr, htrans); end
    hready = 1'b1; hrdata = 32'h0BAD_0040;
    tick();
    hresp = 1'b0; hrdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rd0_wr1 !== 1'b0 || rd_data !== 32'h0BAD_0040)
      begin failures++; $display("FAIL err_rsp got=%b/%b/%b/%h exp=1/1/0/0bad0040", rsp_valid, rsp_err, rsp_rd0_wr1, rd_data); end
    checks++; if (hwdata !== 32'h2222_0044)
      begin failures++; $display("FAIL err_next_hwdata got=%h exp=22220044", hwdata); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rd0_wr1 !== 1'b1)
      begin failures++; $display("FAIL err_next_rsp got=%b/%b/%b exp=1/0/1", rsp_valid, rsp_err, rsp_rd0_wr1); end
    tick();
  endtask

  task automatic test_reset_mid();
    valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h60; wr_data = 32'h3333_0060;
    tick();
    addr = 32'h64; wr_data = 32'h3333_0064;
    tick();                                   // both stages occupied
    valid = 1'b0; hready = 1'b0; #1;
    checks++; if (htrans !== 1'b1 || hwdata !== 32'h3333_0060)
      begin failures++; $display("FAIL rm_pre got=%b/%h exp=1/33330060", htrans, hwdata); end
    rstn = 1'b0; #1;
    checks++; if (htrans !== 1'b0 || haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0)
      begin failures++; $display("FAIL rm_async got=%b/%h/%h/%b exp=0/0/0/0", htrans, haddr, hwdata, hwrite); end
    checks++; if (ready !== 1'b1 || rsp_valid !== 1'b0)
      begin failures++; $display("FAIL rm_ready got=%b/%b exp=1/0", ready, rsp_valid); end
    hready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || ready !== 1'b1 || htrans !== 1'b0)
        begin failures++; $display("FAIL rm_after%0d got=%b/%b/%b exp=0/1/0", c, rsp_valid, ready, htrans); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
